// File: rtl/sha2_round_engine.sv
// SHA-2 compression engine (SHA-256 / SHA-512): one round per accepted W/K pair, then feed-forward add.
// Latency: ROUNDS accepted pairs + 1 FINAL cycle after start; hash_valid pulses the cycle after FINAL.
// Backpressure: wk_ready high only in ROUND; wk_valid low stalls with no state change; abort wins over all.
module sha2_round_engine #(
  parameter int WORD   = 32,
  parameter int ROUNDS = 64,
  localparam int IDXW  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [8*WORD-1:0]   prev_hash,
  input  logic                wk_valid,
  output logic                wk_ready,
  input  logic [WORD-1:0]     cur_w,
  input  logic [WORD-1:0]     cur_k,
  output logic [IDXW-1:0]     round_index,
  output logic                busy,
  output logic                hash_valid,
  output logic [8*WORD-1:0]   updated_hash
);

  // Only the two standard word widths have defined rotation amounts.
  generate
    if (!(WORD == 32 || WORD == 64)) begin : g_bad_word
      $error("sha2_round_engine: WORD must be 32 or 64");
    end
    if (ROUNDS < 1 || ROUNDS > 80) begin : g_bad_rounds
      $error("sha2_round_engine: ROUNDS must be in 1..80");
    end
  endgenerate

  // Big-sigma rotation amounts for the selected word width.
  localparam int S0A = (WORD == 64) ? 28 : 2;
  localparam int S0B = (WORD == 64) ? 34 : 13;
  localparam int S0C = (WORD == 64) ? 39 : 22;
  localparam int S1A = (WORD == 64) ? 14 : 6;
  localparam int S1B = (WORD == 64) ? 18 : 11;
  localparam int S1C = (WORD == 64) ? 41 : 25;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  // Word 0 is 'a' (H0), word 7 is 'h' (H7); this matches the port packing directly.
  typedef logic [7:0][WORD-1:0] words_t;

  state_t          state_q, state_d;
  words_t          work_q, work_d;
  words_t          saved_q, saved_d;
  words_t          digest_q, digest_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            hv_q, hv_d;

  words_t          round_nxt;
  logic [WORD-1:0] big_s0, big_s1, ch, maj, t1, t2;

  function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int n);
    rotr = (x >> n) | (x << (WORD - n));
  endfunction

  // One SHA-2 round applied to the current working variables and the presented W/K.
  always_comb begin
    big_s1    = rotr(work_q[4], S1A) ^ rotr(work_q[4], S1B) ^ rotr(work_q[4], S1C);
    big_s0    = rotr(work_q[0], S0A) ^ rotr(work_q[0], S0B) ^ rotr(work_q[0], S0C);
    ch        = (work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]);
    maj       = (work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]);
    t1        = work_q[7] + big_s1 + ch + cur_k + cur_w;
    t2        = big_s0 + maj;
    round_nxt = work_q;
    round_nxt[7] = work_q[6];
    round_nxt[6] = work_q[5];
    round_nxt[5] = work_q[4];
    round_nxt[4] = work_q[3] + t1;
    round_nxt[3] = work_q[2];
    round_nxt[2] = work_q[1];
    round_nxt[1] = work_q[0];
    round_nxt[0] = t1 + t2;
  end

  // Control FSM and next-state for all datapath registers; abort always returns to IDLE.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    saved_d  = saved_q;
    digest_d = digest_q;
    idx_d    = idx_q;
    hv_d     = 1'b0;
    wk_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          saved_d = prev_hash;
          work_d  = prev_hash;
          idx_d   = '0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        wk_ready = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wk_valid) begin
          work_d = round_nxt;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_FINAL;
          end
        end
      end
      ST_FINAL: begin
        busy    = 1'b1;
        state_d = ST_IDLE;
        if (!abort) begin
          for (int i = 0; i < 8; i++) begin
            digest_d[i] = work_q[i] + saved_q[i];
          end
          hv_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so no partial digest leaks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      saved_q  <= '0;
      digest_q <= '0;
      idx_q    <= '0;
      hv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      saved_q  <= saved_d;
      digest_q <= digest_d;
      idx_q    <= idx_d;
      hv_q     <= hv_d;
    end
  end

  assign round_index  = idx_q;
  assign hash_valid   = hv_q;
  assign updated_hash = digest_q;

endmodule

// File: tb/tb_sha2_round_engine.sv
// Bench for sha2_round_engine: one SHA-256 and one SHA-512 instance, scoreboarded digests.
// Latency: checks hash_valid arrives ROUNDS+2 cycles after start plus one per stall.
// Backpressure: random wk_valid stalls, abort, spurious start and async reset scenarios.
module tb_sha2_round_engine;

  typedef logic [7:0][63:0] h8_t;

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [255:0] IV256  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO256 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] IV512  = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                                     64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                                     64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [511:0] ABC512 = {64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2,
                                     64'h0a9eeee64b55d39a, 64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                                     64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

  logic         clock = 1'b0;
  logic         reset_n, start, abort, wk_valid, sel;
  logic [63:0]  cur_w, cur_k;
  h8_t          ph;
  logic [255:0] ph32;

  logic         wr32, bz32, hv32, wr64, bz64, hv64;
  logic [5:0]   ri32;
  logic [6:0]   ri64;
  logic [255:0] uh32;
  logic [511:0] uh64;

  logic         s_wr, s_bz, s_hv;
  int           s_ri;
  h8_t          s_uh;

  logic [63:0]  msg  [16];
  logic [63:0]  wsch [80];
  h8_t          sb_q [$];
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clock = ~clock;

  sha2_round_engine #(.WORD(32), .ROUNDS(64)) u32 (
    .clock(clock), .reset_n(reset_n), .start(start & ~sel), .abort(abort & ~sel),
    .prev_hash(ph32), .wk_valid(wk_valid), .wk_ready(wr32), .cur_w(cur_w[31:0]),
    .cur_k(cur_k[31:0]), .round_index(ri32), .busy(bz32), .hash_valid(hv32),
    .updated_hash(uh32)
  );

  sha2_round_engine #(.WORD(64), .ROUNDS(80)) u64 (
    .clock(clock), .reset_n(reset_n), .start(start & sel), .abort(abort & sel),
    .prev_hash(ph), .wk_valid(wk_valid), .wk_ready(wr64), .cur_w(cur_w),
    .cur_k(cur_k), .round_index(ri64), .busy(bz64), .hash_valid(hv64),
    .updated_hash(uh64)
  );

  // Narrow the 64-bit lane view of the chaining value for the SHA-256 instance.
  always_comb begin
    ph32 = '0;
    for (int i = 0; i < 8; i++) ph32[i*32 +: 32] = ph[i][31:0];
  end

  // View of the instance currently under test, digest widened to 64-bit lanes.
  always_comb begin
    s_wr = sel ? wr64 : wr32;
    s_bz = sel ? bz64 : bz32;
    s_hv = sel ? hv64 : hv32;
    s_ri = sel ? int'(ri64) : int'(ri32);
    s_uh = '0;
    for (int i = 0; i < 8; i++) s_uh[i] = sel ? uh64[i*64 +: 64] : {32'b0, uh32[i*32 +: 32]};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  function automatic h8_t mk32(input logic [255:0] v);
    h8_t r = '0;
    for (int i = 0; i < 8; i++) r[i] = {32'b0, v[255-32*i -: 32]};
    return r;
  endfunction

  function automatic h8_t mk64(input logic [511:0] v);
    h8_t r = '0;
    for (int i = 0; i < 8; i++) r[i] = v[511-64*i -: 64];
    return r;
  endfunction

  function automatic h8_t rnd_h();
    h8_t r;
    for (int i = 0; i < 8; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  function automatic logic [63:0] msk(input logic [63:0] v, input bit w64);
    return w64 ? v : {32'b0, v[31:0]};
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input bit w64);
    logic [31:0] y, r;
    if (w64) return (x >> n) | (x << (64 - n));
    y = x[31:0];
    r = (y >> n) | (y << (32 - n));
    return {32'b0, r};
  endfunction

  function automatic logic [63:0] kfor(input int t, input bit w64);
    return w64 ? K512[t] : {32'b0, K512[t][63:32]};
  endfunction

  // Expand msg[] into the message schedule for the chosen width.
  task automatic build_sched(input bit w64);
    logic [63:0] x, y, s0, s1;
    for (int t = 0; t < 16; t++) wsch[t] = msk(msg[t], w64);
    for (int t = 16; t < 80; t++) begin
      x  = wsch[t-15];
      y  = wsch[t-2];
      s0 = w64 ? (rr(x, 1, 1) ^ rr(x, 8, 1) ^ (x >> 7))   : (rr(x, 7, 0) ^ rr(x, 18, 0) ^ (x >> 3));
      s1 = w64 ? (rr(y, 19, 1) ^ rr(y, 61, 1) ^ (y >> 6)) : (rr(y, 17, 0) ^ rr(y, 19, 0) ^ (y >> 10));
      wsch[t] = msk(s1 + wsch[t-7] + s0 + wsch[t-16], w64);
    end
  endtask

  // Reference compression of one block (schedule in wsch[]), including feed-forward.
  function automatic h8_t compress(input h8_t hin, input bit w64);
    h8_t v = hin;
    h8_t r;
    logic [63:0] a, e, s0, s1, ch, mj, t1, t2;
    int rounds = w64 ? 80 : 64;
    for (int t = 0; t < rounds; t++) begin
      a  = v[0];
      e  = v[4];
      s1 = w64 ? (rr(e, 14, 1) ^ rr(e, 18, 1) ^ rr(e, 41, 1)) : (rr(e, 6, 0) ^ rr(e, 11, 0) ^ rr(e, 25, 0));
      s0 = w64 ? (rr(a, 28, 1) ^ rr(a, 34, 1) ^ rr(a, 39, 1)) : (rr(a, 2, 0) ^ rr(a, 13, 0) ^ rr(a, 22, 0));
      ch = (e & v[5]) ^ (~e & v[6]);
      mj = (a & v[1]) ^ (a & v[2]) ^ (v[1] & v[2]);
      t1 = msk(v[7] + s1 + ch + kfor(t, w64) + wsch[t], w64);
      t2 = msk(s0 + mj, w64);
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = msk(v[3] + t1, w64);
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = msk(t1 + t2, w64);
    end
    for (int i = 0; i < 8; i++) r[i] = msk(v[i] + hin[i], w64);
    return r;
  endfunction

  task automatic set_abc(input bit w64);
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = w64 ? 64'h6162638000000000 : 64'h0000000061626380;
    msg[15] = 64'h18;
    build_sched(w64);
  endtask

  // Drive one block through the selected instance. abort_at>=0 aborts at that round,
  // spur_at>=0 pulses start (with junk prev_hash) at that round; chain starts the next
  // block in the hash_valid cycle; pre_started means start is already being driven.
  task automatic run_block(input bit w64, input h8_t hin, input h8_t exp, input bit stall,
                           input int abort_at, input int spur_at, input bit pre_started,
                           input bit chain, input h8_t hchain, input h8_t prev_dig);
    int rounds = w64 ? 80 : 64;
    int idx = 0, stalls = 0, cyc = 0;
    bit done = 0, spur_done = 0, v, seen;
    h8_t e;
    sel = w64;
    if (!pre_started) begin
      @(negedge clock);
      ph = hin;
      start = 1'b1;
    end
    if (abort_at < 0) sb_q.push_back(exp);
    while (!done) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      ph = rnd_h();
      if (cyc > 400) begin
        vectors++; miscompares++;
        $display("FAIL timeout: no hash_valid after %0d cycles, required within %0d", cyc, rounds + 2 + stalls);
        done = 1;
      end else if (s_hv) begin
        wk_valid = 1'b0;
        vectors++;
        if (abort_at >= 0) begin
          miscompares++;
          $display("FAIL abort_valid: hash_valid seen at cycle %0d, required none", cyc);
        end else if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: hash_valid with empty queue, required pending digest");
        end else begin
          e = sb_q.pop_front();
          if (s_uh !== e) begin
            miscompares++;
            $display("FAIL digest w64=%0d: got %h, required %h", w64, s_uh, e);
          end
          vectors++;
          if (cyc !== rounds + 2 + stalls) begin
            miscompares++;
            $display("FAIL latency w64=%0d: got %0d cycles, required %0d", w64, cyc, rounds + 2 + stalls);
          end
        end
        if (chain) begin
          ph = hchain;
          start = 1'b1;
        end
        done = 1;
      end else if (s_wr) begin
        vectors++;
        if (s_ri !== idx) begin
          miscompares++;
          $display("FAIL round_index w64=%0d: got %0d, required %0d", w64, s_ri, idx);
        end
        if (abort_at >= 0 && idx == abort_at) begin
          abort = 1'b1;
          wk_valid = 1'b1;
          cur_w = wsch[idx];
          cur_k = kfor(idx, w64);
          @(negedge clock);
          abort = 1'b0;
          vectors++;
          if (s_bz !== 1'b0 || s_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_busy: busy=%b ready=%b, required 0 0", s_bz, s_wr);
          end
          seen = 0;
          for (int k = 0; k < 90; k++) begin
            @(negedge clock);
            wk_valid = 1'(k % 2);
            if (s_hv) seen = 1;
          end
          vectors++;
          if (seen) begin
            miscompares++;
            $display("FAIL abort_valid: hash_valid after abort, required none");
          end
          vectors++;
          if (s_uh !== prev_dig) begin
            miscompares++;
            $display("FAIL abort_hash: got %h, required %h", s_uh, prev_dig);
          end
          wk_valid = 1'b0;
          done = 1;
        end else begin
          if (spur_at >= 0 && idx == spur_at && !spur_done) begin
            start = 1'b1;
            spur_done = 1;
          end
          v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          wk_valid = v;
          cur_w = v ? wsch[idx] : {$urandom, $urandom};
          cur_k = v ? kfor(idx, w64) : {$urandom, $urandom};
          if (v) idx++;
          else stalls++;
        end
      end else begin
        wk_valid = 1'($urandom_range(0, 1));
        cur_w = {$urandom, $urandom};
        cur_k = {$urandom, $urandom};
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; wk_valid = 1'b0; sel = 1'b0;
    cur_w = '0; cur_k = '0; ph = '0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({wr32, bz32, hv32, ri32, uh32} !== '0) begin
      miscompares++;
      $display("FAIL reset32: ready=%b busy=%b valid=%b idx=%0d hash=%h, required all 0", wr32, bz32, hv32, ri32, uh32);
    end
    vectors++;
    if ({wr64, bz64, hv64, ri64, uh64} !== '0) begin
      miscompares++;
      $display("FAIL reset64: ready=%b busy=%b valid=%b idx=%0d hash=%h, required all 0", wr64, bz64, hv64, ri64, uh64);
    end
    reset_n = 1'b1;
    wk_valid = 1'b1;
    @(negedge clock);
    vectors++;
    if (wr32 !== 1'b0 || bz32 !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: ready=%b busy=%b, required 0 0", wr32, bz32);
    end
    wk_valid = 1'b0;
  endtask

  task automatic test_sha256_abc();
    set_abc(0);
    run_block(0, mk32(IV256), mk32(ABC256), 0, -1, -1, 0, 0, '0, '0);
  endtask

  task automatic test_sha512_abc();
    set_abc(1);
    run_block(1, mk64(IV512), mk64(ABC512), 0, -1, -1, 0, 0, '0, '0);
  endtask

  task automatic test_stall();
    set_abc(0);
    run_block(0, mk32(IV256), mk32(ABC256), 1, -1, -1, 0, 0, '0, '0);
  endtask

  task automatic test_abort();
    set_abc(0);
    run_block(0, mk32(IV256), '0, 0, 30, -1, 0, 0, '0, mk32(ABC256));
    run_block(0, mk32(IV256), mk32(ABC256), 0, -1, -1, 0, 0, '0, '0);
  endtask

  task automatic test_spurious_start();
    set_abc(0);
    run_block(0, mk32(IV256), mk32(ABC256), 0, -1, 10, 0, 0, '0, '0);
  endtask

  task automatic test_back_to_back();
    h8_t mid;
    for (int j = 0; j < 16; j++) msg[j] = '0;
    for (int j = 0; j < 14; j++) msg[j] = {32'b0, 8'(97 + j), 8'(98 + j), 8'(99 + j), 8'(100 + j)};
    msg[14] = 64'h80000000;
    build_sched(0);
    mid = compress(mk32(IV256), 0);
    run_block(0, mk32(IV256), mid, 0, -1, -1, 0, 1, mid, '0);
    for (int j = 0; j < 16; j++) msg[j] = '0;
    msg[15] = 64'h1c0;
    build_sched(0);
    run_block(0, mid, mk32(TWO256), 0, -1, -1, 1, 0, '0, '0);
  endtask

  task automatic test_reset_mid_block();
    set_abc(0);
    sel = 1'b0;
    @(negedge clock);
    ph = mk32(IV256);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int t = 0; t < 20; t++) begin
      wk_valid = 1'b1;
      cur_w = wsch[t];
      cur_k = kfor(t, 0);
      @(negedge clock);
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({s_wr, s_bz, s_hv} !== 3'b000 || s_ri !== 0 || s_uh !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: ready=%b busy=%b valid=%b idx=%0d hash=%h, required all 0", s_wr, s_bz, s_hv, s_ri, s_uh);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (s_wr !== 1'b0 || s_bz !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: ready=%b busy=%b, required 0 0", s_wr, s_bz);
    end
    wk_valid = 1'b0;
    run_block(0, mk32(IV256), mk32(ABC256), 0, -1, -1, 0, 0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_sha256_abc();
    test_sha512_abc();
    test_stall();
    test_abort();
    test_spurious_start();
    test_back_to_back();
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
